// File: rtl/mips_cpu_hilo_pkg.sv
// Shared types and constants for the MIPS32 HI/LO unit.
// Build option: MIPS_CPU_HILO_DIV_EN adds the sequential divider and its states.
package mips_cpu_hilo_pkg;

    // Operation codes offered by the execute stage; 7 decodes as NOP.
    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } hilo_op_t;

`ifdef MIPS_CPU_HILO_DIV_EN
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_RUN  = 2'd2,
        ST_DIV_FIX  = 2'd3
    } hilo_state_t;
`else
    // Without the divider only the multiply wait state is needed.
    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MUL_WAIT = 1'b1
    } hilo_state_t;
`endif

    // Restoring divider iterations, one quotient bit per cycle.
    localparam int DIV_STEPS = 32;

endpackage

// File: rtl/mips_cpu_hilo_unit_divider.sv
// Iterative restoring divider for the HI/LO unit (used only when
// MIPS_CPU_HILO_DIV_EN is defined). Operands are converted to magnitudes on
// start; the sign fix and the divide-by-zero result are applied on the
// outputs, so the values are stable once the last step has run.
module mips_cpu_divider
    import mips_cpu_hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             run,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             last_step,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(DIV_STEPS);

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] raw_dvd_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             div_zero_q;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] abs_dvd;
    logic [WIDTH-1:0] abs_dvs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // Operand magnitudes and the trial subtraction for the current step.
    always_comb begin
        dvd_neg = is_signed & dividend[WIDTH-1];
        dvs_neg = is_signed & divisor[WIDTH-1];
        abs_dvd = dvd_neg ? (~dividend + 1'b1) : dividend;
        abs_dvs = dvs_neg ? (~divisor + 1'b1) : divisor;
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, dvs_q};
    end

    // Load on start, then one restoring step per cycle while run is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            raw_dvd_q  <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (start) begin
            count      <= '0;
            rem_q      <= '0;
            quo_q      <= abs_dvd;
            dvs_q      <= abs_dvs;
            raw_dvd_q  <= dividend;
            neg_quo_q  <= dvd_neg ^ dvs_neg;
            neg_rem_q  <= dvd_neg;
            div_zero_q <= (divisor == '0);
        end else if (run) begin
            count <= count + 1'b1;
            if (!diff[WIDTH]) begin
                rem_q <= diff[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= rem_sh[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Final results: divide-by-zero bypasses the sign fix entirely.
    always_comb begin
        last_step = run && (count == CW'(DIV_STEPS - 1));
        if (div_zero_q) begin
            quotient  = '1;
            remainder = raw_dvd_q;
        end else begin
            quotient  = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
            remainder = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        end
    end

endmodule

// File: rtl/mips_cpu_hilo_unit.sv
// HI/LO register unit: MTHI/MTLO writes, external registered multiplier
// hand-off, and (with MIPS_CPU_HILO_DIV_EN defined) a 32-step sequential
// divider. Without the macro DIV/DIVU are accepted as NOPs.
// Handshake: an op is taken on a rising edge when op_valid=1 and busy=0;
// while busy=1 op_valid is ignored and HI/LO hold their values.
module mips_cpu_hilo_unit
    import mips_cpu_hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   rs_val,
    input  logic [WIDTH-1:0]   rt_val,
    output logic               busy,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    output logic               mul_sign,
    input  logic [2*WIDTH-1:0] mul_out
);

    hilo_state_t      state;
    hilo_state_t      state_nxt;
    logic             accept;
    logic             is_mul;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;

    assign accept   = op_valid && (state == ST_IDLE);
    assign is_mul   = (op == OP_MULT) || (op == OP_MULTU);
    assign mul_a    = rs_val;
    assign mul_b    = rt_val;
    assign mul_sign = (op == OP_MULT);
    assign busy     = (state != ST_IDLE);

`ifdef MIPS_CPU_HILO_DIV_EN
    logic             is_div;
    logic             div_last;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;

    assign is_div = (op == OP_DIV) || (op == OP_DIVU);

    mips_cpu_divider #(.WIDTH(WIDTH)) u_divider (
        .clk       (clk),
        .reset     (reset),
        .start     (accept && is_div),
        .run       (state == ST_DIV_RUN),
        .is_signed (op == OP_DIV),
        .dividend  (rs_val),
        .divisor   (rt_val),
        .last_step (div_last),
        .quotient  (div_quo),
        .remainder (div_rem)
    );
`endif

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept && is_mul) begin
                    state_nxt = ST_MUL_WAIT;
                end
`ifdef MIPS_CPU_HILO_DIV_EN
                else if (accept && is_div) begin
                    state_nxt = ST_DIV_RUN;
                end
`endif
            end
            ST_MUL_WAIT: state_nxt = ST_IDLE;
`ifdef MIPS_CPU_HILO_DIV_EN
            ST_DIV_RUN: begin
                if (div_last) begin
                    state_nxt = ST_DIV_FIX;
                end
            end
            ST_DIV_FIX: state_nxt = ST_IDLE;
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // HI/LO write enables and data selected by state.
    always_comb begin
        hi_we = 1'b0;
        lo_we = 1'b0;
        hi_d  = hi;
        lo_d  = lo;
        case (state)
            ST_IDLE: begin
                if (accept && (op == OP_MTHI)) begin
                    hi_we = 1'b1;
                    hi_d  = rs_val;
                end
                if (accept && (op == OP_MTLO)) begin
                    lo_we = 1'b1;
                    lo_d  = rs_val;
                end
            end
            ST_MUL_WAIT: begin
                hi_we = 1'b1;
                lo_we = 1'b1;
                hi_d  = mul_out[2*WIDTH-1:WIDTH];
                lo_d  = mul_out[WIDTH-1:0];
            end
`ifdef MIPS_CPU_HILO_DIV_EN
            ST_DIV_FIX: begin
                hi_we = 1'b1;
                lo_we = 1'b1;
                hi_d  = div_rem;
                lo_d  = div_quo;
            end
`endif
            default: begin
                hi_we = 1'b0;
                lo_we = 1'b0;
            end
        endcase
    end

    // Architectural HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (hi_we) hi <= hi_d;
            if (lo_we) lo <= lo_d;
        end
    end

endmodule

// File: tb/tb_mips_cpu_hilo_unit.sv
// Directed bench for mips_cpu_hilo_unit with a behavioural registered
// multiplier. Each expected entry packs {hi, lo, busy cycles}; the monitor
// pops one whenever busy falls or the driver marks a zero-latency result.
`timescale 1ns/1ps
module tb_mips_cpu_hilo_unit;

    localparam int W  = 32;
    localparam int EW = 2*W + 8;

    localparam logic [2:0] C_NOP   = 3'd0;
    localparam logic [2:0] C_MULT  = 3'd1;
    localparam logic [2:0] C_MULTU = 3'd2;
    localparam logic [2:0] C_DIV   = 3'd3;
    localparam logic [2:0] C_DIVU  = 3'd4;
    localparam logic [2:0] C_MTHI  = 3'd5;
    localparam logic [2:0] C_MTLO  = 3'd6;
    localparam logic [2:0] C_RSVD  = 3'd7;

    logic           clk      = 1'b0;
    logic           reset    = 1'b1;
    logic           op_valid = 1'b0;
    logic [2:0]     op       = 3'd0;
    logic [W-1:0]   rs_val   = '0;
    logic [W-1:0]   rt_val   = '0;
    logic           busy;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_sign;
    logic [2*W-1:0] mul_out  = '0;

    logic [EW-1:0]  exp_q[$];
    int             errors    = 0;
    int             checks    = 0;
    int             busy_cnt  = 0;
    logic           prev_busy = 1'b0;
    logic           mark      = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    mips_cpu_hilo_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_sign (mul_sign),
        .mul_out  (mul_out)
    );

    // Behavioural multiplier with one registered stage.
    always @(posedge clk) begin
        if (mul_sign)
            mul_out <= {{W{mul_a[W-1]}}, mul_a} * {{W{mul_b[W-1]}}, mul_b};
        else
            mul_out <= {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
    end

    // ---------------- driver tasks ----------------
    task automatic push_exp(input logic [W-1:0] h, input logic [W-1:0] l, input int c);
        exp_q.push_back({h, l, c[7:0]});
    endtask

    // Called just after a rising edge with busy low; the op is taken on the next edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op_valid = 1'b1;
        op       = o;
        rs_val   = a;
        rt_val   = b;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op       = C_NOP;
    endtask

    task automatic pulse_mark();
        mark = 1'b1;
        @(posedge clk);
        #1;
        mark = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (busy && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy still %0b after %0d cycles, expected 0", busy, n);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (busy === 1'b1) busy_cnt++;
        if ((prev_busy === 1'b1 && busy === 1'b0) || mark) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: hi=%h lo=%h with empty queue, expected no result", hi, lo);
            end else begin
                e = exp_q.pop_front();
                chk("hi", hi, e[EW-1:EW-W]);
                chk("lo", lo, e[EW-W-1:8]);
                chk("busy_cycles", W'(busy_cnt), W'(e[7:0]));
            end
            busy_cnt = 0;
        end
        prev_busy = busy;
    end

`ifdef MIPS_CPU_HILO_DIV_EN
    // Directed divide vectors: op, rs, rt, expected lo (quotient), expected hi (remainder).
    logic [2:0]   dv_op [6] = '{C_DIV, C_DIVU, C_DIVU, C_DIV, C_DIV, C_DIV};
    logic [W-1:0] dv_rs [6] = '{32'hFFFF_FFF9, 32'd100, 32'hDEAD_BEEF, 32'h8000_0000, 32'd7, 32'hFFFF_FFF9};
    logic [W-1:0] dv_rt [6] = '{32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0};
    logic [W-1:0] dv_lo [6] = '{32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    logic [W-1:0] dv_hi [6] = '{32'hFFFF_FFFF, 32'd2, 32'hDEAD_BEEF, 32'd0, 32'd1, 32'hFFFF_FFF9};
`endif

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset values.
        push_exp(32'h0, 32'h0, 0);
        pulse_mark();

        // MTHI / MTLO: visible the cycle after accept, no busy.
        push_exp(32'h1234_5678, 32'h0, 0);
        issue(C_MTHI, 32'h1234_5678, 32'h0);
        pulse_mark();
        push_exp(32'h1234_5678, 32'hCAFE_F00D, 0);
        issue(C_MTLO, 32'hCAFE_F00D, 32'h0);
        pulse_mark();

        // Multiplies, back to back.
        push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFA, 1);
        issue(C_MULT, 32'hFFFF_FFFE, 32'd3);
        wait_idle(5);
        push_exp(32'h0000_0002, 32'hFFFF_FFFA, 1);
        issue(C_MULTU, 32'hFFFF_FFFE, 32'd3);
        wait_idle(5);
        push_exp(32'h4000_0000, 32'h0, 1);
        issue(C_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_idle(5);

        // NOP codes leave HI/LO alone.
        push_exp(32'h4000_0000, 32'h0, 0);
        issue(C_RSVD, 32'h1111_1111, 32'h2222_2222);
        pulse_mark();
        push_exp(32'h4000_0000, 32'h0, 0);
        issue(C_NOP, 32'h3333_3333, 32'h4444_4444);
        pulse_mark();

`ifdef MIPS_CPU_HILO_DIV_EN
        for (int i = 0; i < 6; i++) begin
            push_exp(dv_hi[i], dv_lo[i], 33);
            issue(dv_op[i], dv_rs[i], dv_rt[i]);
            wait_idle(40);
        end

        // MTLO offered while the divider runs is ignored.
        push_exp(32'd2, 32'd3, 33);
        issue(C_DIV, 32'd20, 32'd6);
        op_valid = 1'b1;
        op       = C_MTLO;
        rs_val   = 32'd5;
        repeat (5) @(posedge clk);
        #1;
        op_valid = 1'b0;
        op       = C_NOP;
        wait_idle(40);
        push_exp(32'd2, 32'd3, 0);
        pulse_mark();

        // Reset on the tenth busy cycle discards the divide.
        push_exp(32'h0, 32'h0, 10);
        issue(C_DIV, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
`else
        // Divider not built: DIV/DIVU are NOPs.
        push_exp(32'h4000_0000, 32'h0, 0);
        issue(C_DIV, 32'd10, 32'd3);
        pulse_mark();
        push_exp(32'h4000_0000, 32'h0, 0);
        issue(C_DIVU, 32'd10, 32'd3);
        pulse_mark();

        // Reset clears HI/LO.
        push_exp(32'h0, 32'h0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        pulse_mark();
`endif

        // New op accepted right after the interrupted/finished sequence.
        push_exp(32'hA5A5_0001, 32'h0, 0);
        issue(C_MTHI, 32'hA5A5_0001, 32'h0);
        pulse_mark();

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_cpu_hilo_unit.md
# mips_cpu_hilo_unit

HI/LO register unit for the MIPS32 core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from the execute stage. It drives the registered 64-bit multiplier and captures its product one cycle later, and it runs a 32-iteration sequential divider. It holds the architectural HI/LO registers that MFHI/MFLO read, and asserts `busy` so that the pipeline stalls HI/LO consumers.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `op_valid` input 1: operation offered this cycle.
- `op` input 3: operation code: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; codes 7 and above are NOP.
- `rs_val` input WIDTH: dividend, multiplicand, or MTHI/MTLO source.
- `rt_val` input WIDTH: divisor or multiplier.
- `busy` output 1: an operation is in flight; `op_valid` is ignored while this is high.
- `hi` output WIDTH: architectural HI register.
- `lo` output WIDTH: architectural LO register.
- `mul_a` output WIDTH: multiplier operand a, equal to `rs_val` combinationally.
- `mul_b` output WIDTH: multiplier operand b, equal to `rt_val` combinationally.
- `mul_sign` output 1: combinational; 1 when `op` is MULT, else 0.
- `mul_out` input 2*WIDTH: multiplier product, registered inside the multiplier with 1 cycle of latency.

## Operation
- An operation is accepted on a rising edge when `op_valid` is 1, `busy` is 0 and `reset` is 0.
- States: IDLE, MUL_WAIT, DIV_RUN, DIV_FIX.
- IDLE with MTHI accepted: `hi <= rs_val` on the accept edge; the unit stays in IDLE with no busy cycle.
- IDLE with MTLO accepted: `lo <= rs_val` on the accept edge; the unit stays in IDLE with no busy cycle.
- IDLE with MULT or MULTU accepted:
  - The multiplier samples `mul_a`/`mul_b` on the same edge.
  - The unit moves to MUL_WAIT.
  - On the next edge: `{hi,lo} <= mul_out`, then back to IDLE.
- IDLE with DIV or DIVU accepted:
  - The sub-module loads |rs| and |rt| (raw values for DIVU), a counter of 0, and sign flags.
  - The unit moves to DIV_RUN.
- DIV_RUN: one restoring step per cycle: shift the remainder, trial-subtract, set the quotient bit. After 32 steps (counter reaches 31) the unit moves to DIV_FIX.
- DIV_FIX, sign correction for DIV only:
  - The quotient is negated if the operand signs differ, so it truncates toward zero.
  - The remainder takes the sign of the dividend.
  - `lo <= quotient`, `hi <= remainder`, then back to IDLE.
- Arithmetic rules:
  - Divide by zero, both DIV and DIVU, with full latency: `lo = 32'hFFFF_FFFF`, `hi = rs_val`, with no sign fix.
  - DIV of 0x8000_0000 by 0xFFFF_FFFF: `lo = 0x8000_0000`, `hi = 0`; the result wraps and no trap is raised.
  - MULT is a signed 64-bit product; MULTU is an unsigned 64-bit product.
- Reset, including in mid-operation: the state machine goes to IDLE and the counter to 0. Any in-flight result is discarded.
- Reset values: `hi = 0`, `lo = 0`, `busy = 0`.
- NOP, or `op_valid` = 0: no state change.

## Timing
- Let E0 be the accept edge.
- MTHI/MTLO: the new value is visible on `hi`/`lo` in the cycle after E0.
- MULT/MULTU: `busy` is high for 1 cycle, between E0 and E1. HI/LO are written at E1.
- DIV/DIVU: `busy` is high from after E0 until E33 (33 cycles). Steps run at E1..E32, and the DIV_FIX write happens at E33.
- `busy` is a registered output, high exactly when the state is not IDLE.
- `hi`/`lo` hold their previous values while `busy` is high.
- A new op can be accepted on the edge after `busy` falls.

## Configuration
- Macro `MIPS_CPU_HILO_DIV_EN`.
- Defined: the divider is instantiated and DIV/DIVU behave as specified above.
- Undefined:
  - No divider logic is built, and the DIV_RUN/DIV_FIX states do not exist.
  - DIV/DIVU are accepted as NOPs: HI/LO are unchanged and `busy` stays 0.

## Structure
- Package `mips_cpu_hilo_pkg` holds:
  - the `hilo_op_t` enum (the 3-bit codes above);
  - the `hilo_state_t` enum;
  - the constant `DIV_STEPS = 32`.
- Sub-module `mips_cpu_divider`: iterative restoring divider with start/done, including sign handling and the divide-by-zero rule. It is instantiated only under `MIPS_CPU_HILO_DIV_EN`.
- The multiplier stays external; this unit only drives and consumes it.

## Test plan
- Reset, then MTHI 0x1234_5678 and MTLO 0xCAFE_F00D: `hi = 0x12345678`, `lo = 0xCAFEF00D` one cycle later, and `busy` never rises.
- MULT rs = 0xFFFF_FFFE (-2), rt = 3, with a behavioural multiplier model: `busy` is high for 1 cycle, then `hi = 0xFFFF_FFFF`, `lo = 0xFFFF_FFFA`. MULTU with the same operands gives `hi = 0x2`, `lo = 0xFFFF_FFFA`.
- DIV rs = -7, rt = 2: `busy` is high for 33 cycles, then `lo = 0xFFFF_FFFD` (-3) and `hi = 0xFFFF_FFFF` (-1). DIVU 100/7 gives `lo = 14`, `hi = 2`.
- DIVU rs = 0xDEAD_BEEF, rt = 0: after 33 cycles `lo = 0xFFFF_FFFF`, `hi = 0xDEAD_BEEF`. DIV of 0x8000_0000 by -1 gives `lo = 0x8000_0000`, `hi = 0`.
- Offer MTLO 5 while a DIV is running: the MTLO is ignored and `lo` equals the quotient after completion. Assert `reset` at cycle 10 of a DIV: `hi = lo = 0` and `busy = 0` on the next cycle.
- With `MIPS_CPU_HILO_DIV_EN` undefined, DIV 10/3: `busy` stays 0 and HI/LO are unchanged.
